// File: rtl/multi_stage_pipeline_controller_pkg.sv
// ----------------------------------------------------------------------------
// PipelineControllerTypes
// Shared types for the multi-stage pipeline controller.
//   SerializeState : serialise/drain FSM encoding
//   StageIndex     : unsigned stage index used for flush-range compares
//   clamp_index    : limits a requested flush index to the oldest stage
// ----------------------------------------------------------------------------
package PipelineControllerTypes;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } SerializeState;

    typedef int unsigned StageIndex;

    function automatic StageIndex clamp_index(input StageIndex idx, input StageIndex last_idx);
        return (idx > last_idx) ? last_idx : idx;
    endfunction

endpackage

// File: rtl/multi_stage_pipeline_controller_if.sv
// ----------------------------------------------------------------------------
// multi_stage_pipeline_controller_if
// Request/status bundle between the pipeline and its controller.
//   master : pipeline side, drives stall/flush/serialise requests
//   slave  : controller side, drives stall/flush/bubble enables and status
// Signals:
//   stallReq, stageValid   per-stage request / valid
//   flushReq, flushIndex   flush stages 0..flushIndex
//   serializeReq           serialising instruction waiting at its stage
//   stall, flush, bubble   per-stage enables
//   serializeDone          downstream drained
//   stallTimeout           stall watchdog expired
//   stallCycles, flushCount wrapping event counters
// ----------------------------------------------------------------------------
interface multi_stage_pipeline_controller_if #(
    parameter int STAGE_COUNT   = 6,
    parameter int COUNTER_WIDTH = 32
) ();
    localparam int IDX_W = $clog2(STAGE_COUNT);

    logic [STAGE_COUNT-1:0]   stallReq;
    logic [STAGE_COUNT-1:0]   stageValid;
    logic                     flushReq;
    logic [IDX_W-1:0]         flushIndex;
    logic                     serializeReq;
    logic [STAGE_COUNT-1:0]   stall;
    logic [STAGE_COUNT-1:0]   flush;
    logic [STAGE_COUNT-1:0]   bubble;
    logic                     serializeDone;
    logic                     stallTimeout;
    logic [COUNTER_WIDTH-1:0] stallCycles;
    logic [COUNTER_WIDTH-1:0] flushCount;

    modport master (
        output stallReq, stageValid, flushReq, flushIndex, serializeReq,
        input  stall, flush, bubble, serializeDone, stallTimeout, stallCycles, flushCount
    );

    modport slave (
        input  stallReq, stageValid, flushReq, flushIndex, serializeReq,
        output stall, flush, bubble, serializeDone, stallTimeout, stallCycles, flushCount
    );
endinterface

// File: rtl/multi_stage_pipeline_controller_event_counter.sv
// ----------------------------------------------------------------------------
// pipeline_event_counter
// Free-running event counter, wraps modulo 2^WIDTH.
//   clk   : clock
//   clr   : synchronous clear (has priority over en)
//   en    : count this cycle
//   count : current count
// ----------------------------------------------------------------------------
module pipeline_event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/multi_stage_pipeline_controller.sv
// ----------------------------------------------------------------------------
// multi_stage_pipeline_controller
// Drives per-stage stall/flush/bubble enables for an STAGE_COUNT-deep pipeline
// (stage 0 = fetch, youngest). Adds a serialise/drain FSM, a stall watchdog and
// two wrapping event counters.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pc       : controller side (slave) of multi_stage_pipeline_controller_if
//
// Serialise FSM:
//   state | meaning
//   IDLE  | no serialising instruction outstanding
//   DRAIN | holding stages 0..SERIALIZE_STAGE until older stages are empty
// ----------------------------------------------------------------------------
module multi_stage_pipeline_controller
    import PipelineControllerTypes::*;
#(
    parameter int STAGE_COUNT     = 6,
    parameter int SERIALIZE_STAGE = 2,
    parameter int STALL_LIMIT     = 1023,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic clk,
    input  logic rst,
    multi_stage_pipeline_controller_if.slave pc
);
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    SerializeState          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STAGE_COUNT-1:0] rs_vec, flush_vec, stall_vec, bubble_vec;
    StageIndex              fi;
    logic                   down_empty;
    logic                   abort;
    logic                   drain_hold;
    logic                   serialize_done;

    assign fi         = clamp_index(StageIndex'(pc.flushIndex), StageIndex'(STAGE_COUNT - 1));
    assign down_empty = ~|pc.stageValid[STAGE_COUNT-1:SERIALIZE_STAGE+1];
    // A flush reaching the serialising stage kills the instruction being drained for.
    assign abort      = pc.flushReq & (fi >= StageIndex'(SERIALIZE_STAGE));

    always_comb begin
        state_d        = state_q;
        drain_hold     = 1'b0;
        serialize_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pc.serializeReq && !abort) begin
                    drain_hold = 1'b1;
                    if (down_empty) begin
                        serialize_done = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    drain_hold = 1'b1;
                    if (down_empty) begin
                        serialize_done = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            drain_hold     = 1'b0;
            serialize_done = 1'b0;
        end
    end

    always_comb begin
        logic acc;
        acc        = 1'b0;
        rs_vec     = '0;
        flush_vec  = '0;
        stall_vec  = '0;
        bubble_vec = '0;
        // A stall in an older stage backs up every younger stage behind it.
        for (int i = STAGE_COUNT - 1; i >= 0; i--) begin
            acc       = acc | pc.stallReq[i];
            rs_vec[i] = acc;
        end
        for (int i = 0; i < STAGE_COUNT; i++) begin
            flush_vec[i] = pc.flushReq & (StageIndex'(i) <= fi);
            stall_vec[i] = (rs_vec[i] | (drain_hold & (i <= SERIALIZE_STAGE) & ~down_empty))
                           & ~flush_vec[i];
        end
        for (int i = 1; i < STAGE_COUNT; i++) begin
            bubble_vec[i] = stall_vec[i-1] & ~stall_vec[i] & ~flush_vec[i];
        end
        if (rst) begin
            flush_vec  = '1;
            stall_vec  = '0;
            bubble_vec = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pc.flushReq || !(|pc.stallReq)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STALL_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc.stall         = stall_vec;
    assign pc.flush         = flush_vec;
    assign pc.bubble        = bubble_vec;
    assign pc.serializeDone = serialize_done;
    assign pc.stallTimeout  = ~rst & (cnt_q == CNT_W'(STALL_LIMIT));

    pipeline_event_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cycles (
        .clk   (clk),
        .clr   (rst),
        .en    (|stall_vec),
        .count (pc.stallCycles)
    );

    pipeline_event_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_count (
        .clk   (clk),
        .clr   (rst),
        .en    (pc.flushReq),
        .count (pc.flushCount)
    );
endmodule

// File: tb/tb_multi_stage_pipeline_controller.sv
module tb_multi_stage_pipeline_controller;

    typedef struct {
        logic [5:0] stall;
        logic [5:0] flush;
        logic [5:0] bubble;
        logic       done;
        logic       timeout;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   wd       = 0;
    logic [3:0] e_sc = 4'd0;
    logic [3:0] e_fc = 4'd0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multi_stage_pipeline_controller_if #(.STAGE_COUNT(6), .COUNTER_WIDTH(4)) pc ();

    multi_stage_pipeline_controller #(
        .STAGE_COUNT     (6),
        .SERIALIZE_STAGE (2),
        .STALL_LIMIT     (4),
        .COUNTER_WIDTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pc  (pc)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, compare at negedge,
    // then advance the bench model of watchdog and counters.
    task automatic step(input string name, input logic r, input logic [5:0] sreq,
                        input logic [5:0] sv, input logic fr, input logic [2:0] fidx,
                        input logic ser, input logic [5:0] es, input logic [5:0] ef,
                        input logic [5:0] eb, input logic ed);
        exp_t e;
        exp_t got;
        rst             = r;
        pc.stallReq     = sreq;
        pc.stageValid   = sv;
        pc.flushReq     = fr;
        pc.flushIndex   = fidx;
        pc.serializeReq = ser;
        e.stall   = es;
        e.flush   = ef;
        e.bubble  = eb;
        e.done    = ed;
        e.timeout = !r && (wd == 4);
        e.sc      = e_sc;
        e.fc      = e_fc;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check($sformatf("%s.stall", name),   {2'b0, pc.stall},         {2'b0, got.stall});
        check($sformatf("%s.flush", name),   {2'b0, pc.flush},         {2'b0, got.flush});
        check($sformatf("%s.bubble", name),  {2'b0, pc.bubble},        {2'b0, got.bubble});
        check($sformatf("%s.done", name),    {7'b0, pc.serializeDone}, {7'b0, got.done});
        check($sformatf("%s.timeout", name), {7'b0, pc.stallTimeout},  {7'b0, got.timeout});
        check($sformatf("%s.stallCycles", name), {4'b0, pc.stallCycles}, {4'b0, got.sc});
        check($sformatf("%s.flushCount", name),  {4'b0, pc.flushCount},  {4'b0, got.fc});
        if (r) begin
            wd   = 0;
            e_sc = 4'd0;
            e_fc = 4'd0;
        end else begin
            if (fr || sreq == 6'd0) wd = 0;
            else if (wd < 4) wd++;
            if (es != 6'd0) e_sc = e_sc + 4'd1;
            if (fr) e_fc = e_fc + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        pc.stallReq     = '0;
        pc.stageValid   = '0;
        pc.flushReq     = 1'b0;
        pc.flushIndex   = '0;
        pc.serializeReq = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // reset behaviour
        step("rst0", 1, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b111111, 6'b000000, 0);
        step("rst1", 1, 6'b001000, 6'b111111, 0, 0, 1, 6'b000000, 6'b111111, 6'b000000, 0);
        step("idle", 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);

        // stall fan-out and bubbles
        for (int k = 0; k < 3; k++)
            step("st3", 0, 6'b001000, 6'b000000, 0, 0, 0, 6'b001111, 6'b000000, 6'b010000, 0);
        step("st5", 0, 6'b100000, 6'b000000, 0, 0, 0, 6'b111111, 6'b000000, 6'b000000, 0);
        step("st0", 0, 6'b000001, 6'b000000, 0, 0, 0, 6'b000001, 6'b000000, 6'b000010, 0);
        step("st14", 0, 6'b010010, 6'b000000, 0, 0, 0, 6'b011111, 6'b000000, 6'b100000, 0);
        step("idle", 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);

        // flush ranges; flush wins over stall, index clamps to oldest stage
        step("fl2", 0, 6'b000100, 6'b000000, 1, 2, 0, 6'b000000, 6'b000111, 6'b000000, 0);
        step("fl7", 0, 6'b000000, 6'b000000, 1, 7, 0, 6'b000000, 6'b111111, 6'b000000, 0);
        step("fl0", 0, 6'b100000, 6'b000000, 1, 0, 0, 6'b111110, 6'b000001, 6'b000000, 0);
        step("idle", 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);

        // serialise drain over three retirements
        step("dr0", 0, 6'b000000, 6'b111111, 0, 0, 1, 6'b000111, 6'b000000, 6'b001000, 0);
        step("dr1", 0, 6'b000000, 6'b110111, 0, 0, 1, 6'b000111, 6'b000000, 6'b001000, 0);
        step("dr2", 0, 6'b000000, 6'b100111, 0, 0, 1, 6'b000111, 6'b000000, 6'b001000, 0);
        step("dr3", 0, 6'b000000, 6'b000111, 0, 0, 1, 6'b000000, 6'b000000, 6'b000000, 1);
        step("dri", 0, 6'b000000, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
        // already drained: immediate done, no state change
        step("imm", 0, 6'b000000, 6'b000111, 0, 0, 1, 6'b000000, 6'b000000, 6'b000000, 1);
        step("immi", 0, 6'b000000, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);

        // flush during drain: young flush keeps DRAIN, deep flush aborts
        step("ab0", 0, 6'b000000, 6'b111111, 0, 0, 1, 6'b000111, 6'b000000, 6'b001000, 0);
        step("ab1", 0, 6'b000000, 6'b111111, 1, 1, 1, 6'b000100, 6'b000011, 6'b001000, 0);
        step("ab2", 0, 6'b000000, 6'b111111, 0, 0, 0, 6'b000111, 6'b000000, 6'b001000, 0);
        step("ab4", 0, 6'b000000, 6'b111111, 1, 4, 0, 6'b000000, 6'b011111, 6'b000000, 0);
        step("ab5", 0, 6'b000000, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
        // abort at exactly SERIALIZE_STAGE beats serializeReq in IDLE
        step("abi", 0, 6'b000000, 6'b111111, 1, 2, 1, 6'b000000, 6'b000111, 6'b000000, 0);
        step("abj", 0, 6'b000000, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);

        // watchdog: timeout from 5th request cycle, idle or flush clears it
        for (int k = 0; k < 6; k++)
            step("wd", 0, 6'b000001, 6'b000000, 0, 0, 0, 6'b000001, 6'b000000, 6'b000010, 0);
        step("wdi0", 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
        step("wdi1", 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
        for (int k = 0; k < 5; k++)
            step("wdb", 0, 6'b000001, 6'b000000, 0, 0, 0, 6'b000001, 6'b000000, 6'b000010, 0);
        step("wdf", 0, 6'b000001, 6'b000000, 1, 0, 0, 6'b000000, 6'b000001, 6'b000000, 0);
        step("wdg", 0, 6'b000001, 6'b000000, 0, 0, 0, 6'b000001, 6'b000000, 6'b000010, 0);

        // flushCount wrap
        step("rstw", 1, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b111111, 6'b000000, 0);
        for (int k = 0; k < 16; k++)
            step("fw", 0, 6'b000000, 6'b000000, 1, 0, 0, 6'b000000, 6'b000001, 6'b000000, 0);
        step("fwe", 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
        check("fc_wrap", {4'b0, pc.flushCount}, 8'd0);

        // reset mid-drain drops the drain without serializeDone
        step("md0", 0, 6'b000000, 6'b111111, 1, 0, 1, 6'b000110, 6'b000001, 6'b001000, 0);
        step("md1", 0, 6'b000000, 6'b111111, 0, 0, 1, 6'b000111, 6'b000000, 6'b001000, 0);
        step("mdr", 1, 6'b000000, 6'b111111, 0, 0, 1, 6'b000000, 6'b111111, 6'b000000, 0);
        step("mdx", 0, 6'b000000, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
        check("rst_sc", {4'b0, pc.stallCycles}, 8'd0);
        check("rst_fc", {4'b0, pc.flushCount}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
